// File: rtl/sine_sweep_ctrl_if.sv
// Avalon-MM slave bus bundle for the sine sweep sequencer.
// The master drives select, strobes, address and write data. The slave
// returns registered read data.
interface sine_sweep_ctrl_if;
  logic        ChipSelect;
  logic        Write;
  logic        Read;
  logic [1:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output ChipSelect, Write, Read, Address, WriteData,
    input  ReadData
  );

  modport slave (
    input  ChipSelect, Write, Read, Address, WriteData,
    output ReadData
  );
endinterface

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer for the sine generator path.
// It steps fcw from a start value to a stop value with a programmable dwell
// per step. Sweeps can be single-pass or looping.
// Optional feature macro SINE_SWEEP_PASSCNT_EN: STAT[31:16] holds a 16-bit
// count of completed passes. Without the macro that field reads 0 and the
// counter is not built.
module sine_sweep_ctrl #(
  parameter int FCW_W   = 8,
  parameter int DWELL_W = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  sine_sweep_ctrl_if.slave  bus,
  output logic              run,
  output logic [FCW_W-1:0]  fcw,
  output logic              irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Programmer-visible registers
  logic               ctrl_loop;
  logic               ctrl_irq_en;
  logic [23:0]        cfg_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic               done_flag;

  // Working copies captured at LOAD, so that register rewrites mid-sweep
  // do not disturb the pass in progress
  logic [FCW_W-1:0]   stop_w;
  logic [FCW_W-1:0]   step_w;
  logic [DWELL_W-1:0] dwell_w;
  logic               dir_up;
  logic [DWELL_W-1:0] cnt;

  logic               wr_en;
  logic               rd_en;
  logic               start_req;
  logic               stop_req;
  logic               end_of_pass;
  logic [FCW_W-1:0]   next_fcw;
  logic [FCW_W:0]     sum_up;
  logic [FCW_W:0]     diff_dn;
  logic [FCW_W-1:0]   cfg_start;
  logic [FCW_W-1:0]   cfg_stop;
  logic [FCW_W-1:0]   cfg_step;
  logic [15:0]        pass_field;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  assign wr_en     = bus.ChipSelect & bus.Write;
  assign rd_en     = bus.ChipSelect & bus.Read;
  assign start_req = wr_en && (bus.Address == 2'd0) && bus.WriteData[0];
  assign stop_req  = wr_en && (bus.Address == 2'd0) && bus.WriteData[1];

  assign cfg_start = FCW_W'(cfg_reg[7:0]);
  assign cfg_stop  = FCW_W'(cfg_reg[15:8]);
  assign cfg_step  = FCW_W'(cfg_reg[23:16]);

  assign end_of_pass  = (fcw == stop_w) || (step_w == '0);
  assign irq          = done_flag & ctrl_irq_en;
  assign unused_wdata = ^bus.WriteData[31:24];

  // Next fcw is computed one bit wider so the clamp catches overflow and underflow
  always_comb begin
    sum_up   = {1'b0, fcw} + {1'b0, step_w};
    diff_dn  = {1'b0, fcw} - {1'b0, step_w};
    next_fcw = stop_w;
    if (dir_up) begin
      if (sum_up <= {1'b0, stop_w}) next_fcw = sum_up[FCW_W-1:0];
    end else begin
      if (!diff_dn[FCW_W] && (diff_dn[FCW_W-1:0] >= stop_w)) next_fcw = diff_dn[FCW_W-1:0];
    end
  end

  // Sequencer state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next-state logic; STOP overrides everything
  always_comb begin
    state_d = state_q;
    if (stop_req) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_req) state_d = S_LOAD;
        S_LOAD:  state_d = S_DWELL;
        S_DWELL: if (cnt == '0) state_d = S_STEP;
        S_STEP: begin
          if (end_of_pass) state_d = ctrl_loop ? S_LOAD : S_DONE;
          else             state_d = S_DWELL;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sweep datapath: working config, dwell counter, fcw and run
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fcw     <= '0;
      run     <= 1'b0;
      cnt     <= '0;
      stop_w  <= '0;
      step_w  <= '0;
      dwell_w <= '0;
      dir_up  <= 1'b1;
    end else if (stop_req) begin
      run <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          stop_w  <= cfg_stop;
          step_w  <= cfg_step;
          dwell_w <= dwell_reg;
          dir_up  <= (cfg_stop >= cfg_start);
          fcw     <= cfg_start;
          cnt     <= dwell_reg;
          run     <= 1'b1;
        end
        S_DWELL: begin
          if (cnt != '0) cnt <= cnt - DWELL_W'(1);
        end
        S_STEP: begin
          if (!end_of_pass) begin
            fcw <= next_fcw;
            cnt <= dwell_w;
          end
        end
        S_DONE: run <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SINE_SWEEP_PASSCNT_EN
  logic [15:0] pass_cnt;

  // Completed-pass counter, restarted whenever a fresh sweep is launched
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pass_cnt <= '0;
    end else if (!stop_req) begin
      if (state_q == S_IDLE && start_req)          pass_cnt <= '0;
      else if (state_q == S_STEP && end_of_pass)   pass_cnt <= pass_cnt + 16'd1;
    end
  end

  assign pass_field = pass_cnt;
`else
  assign pass_field = 16'd0;
`endif

  // Readback mux; pulse bits and unimplemented bits read as 0
  always_comb begin
    rd_mux = '0;
    case (bus.Address)
      2'd0: rd_mux = {28'd0, ctrl_irq_en, ctrl_loop, 2'b00};
      2'd1: rd_mux = {8'd0, cfg_reg};
      2'd2: rd_mux = 32'(dwell_reg);
      2'd3: rd_mux = {pass_field, 8'(fcw), 6'd0, done_flag, (state_q != S_IDLE)};
      default: rd_mux = '0;
    endcase
  end

  // Register writes, DONE set/clear (set wins) and registered read data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_loop    <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      cfg_reg      <= '0;
      dwell_reg    <= '0;
      done_flag    <= 1'b0;
      bus.ReadData <= '0;
    end else begin
      if (wr_en) begin
        case (bus.Address)
          2'd0: begin
            ctrl_loop   <= bus.WriteData[2];
            ctrl_irq_en <= bus.WriteData[3];
          end
          2'd1: cfg_reg   <= bus.WriteData[23:0];
          2'd2: dwell_reg <= bus.WriteData[DWELL_W-1:0];
          default: ;
        endcase
      end
      if (state_q == S_DONE && !stop_req) done_flag <= 1'b1;
      else if (wr_en && bus.Address == 2'd3 && bus.WriteData[1]) done_flag <= 1'b0;
      if (rd_en) bus.ReadData <= rd_mux;
    end
  end

endmodule
